// File: rtl/clock_divider_pkg.sv
// Shared types and defaults for the programmable integer clock divider.
package clock_divider_pkg;

  localparam int unsigned DEFAULT_RATIO_WIDTH = 8;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

endpackage

// File: rtl/clock_divider_clk_bypass_mux.sv
// 2:1 clock select between the reference clock and the divided level.
// Kept standalone so a glitch-free clock-mux cell can replace it later.
module clock_divider_clk_bypass_mux (
  input  logic i_ref_clk,
  input  logic i_div_clk,
  input  logic i_sel_div,
  output logic o_clk
);

  assign o_clk = i_sel_div ? i_div_clk : i_ref_clk;

endmodule

// File: rtl/clock_divider.sv
// Integer clock divider: high phase N>>1, low phase N-(N>>1) reference cycles;
// bypass passes i_ref_clk through when disabled or N < 2.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = DEFAULT_RATIO_WIDTH
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_clk_en,
  input  logic [RATIO_WIDTH-1:0] i_div_ratio,
  output logic                   o_div_clk
);

  logic                   bypass_c;
  logic [RATIO_WIDTH-1:0] high_len_c;
  logic [RATIO_WIDTH-1:0] low_len_c;
  logic [RATIO_WIDTH-1:0] high_last_c;
  logic [RATIO_WIDTH-1:0] low_last_c;

  logic [RATIO_WIDTH-1:0] cnt_q;
  logic [RATIO_WIDTH-1:0] cnt_d;
  phase_e                 phase_q;
  phase_e                 phase_d;

  assign bypass_c    = !i_clk_en
                     || (i_div_ratio == RATIO_WIDTH'(0))
                     || (i_div_ratio == RATIO_WIDTH'(1));
  assign high_len_c  = i_div_ratio >> 1;
  assign low_len_c   = i_div_ratio - high_len_c;
  assign high_last_c = high_len_c - RATIO_WIDTH'(1);
  assign low_last_c  = low_len_c - RATIO_WIDTH'(1);

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      phase_q <= PH_LOW;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // >= compare ends an over-long phase at once after a ratio decrease.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (bypass_c) begin
      cnt_d   = '0;
      phase_d = PH_LOW;
    end else begin
      unique case (phase_q)
        PH_HIGH: begin
          if (cnt_q >= high_last_c) begin
            cnt_d   = '0;
            phase_d = PH_LOW;
          end else begin
            cnt_d = cnt_q + RATIO_WIDTH'(1);
          end
        end
        PH_LOW: begin
          if (cnt_q >= low_last_c) begin
            cnt_d   = '0;
            phase_d = PH_HIGH;
          end else begin
            cnt_d = cnt_q + RATIO_WIDTH'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          phase_d = PH_LOW;
        end
      endcase
    end
  end

  clock_divider_clk_bypass_mux u_clk_mux (
    .i_ref_clk (i_ref_clk),
    .i_div_clk (phase_q == PH_HIGH),
    .i_sel_div (!bypass_c),
    .o_clk     (o_div_clk)
  );

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: behavioural phase model plus pinned patterns.
module tb_clock_divider;

  localparam int unsigned RW = 5;

  logic          ref_clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [RW-1:0] div_ratio;
  logic          div_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  clock_divider #(.RATIO_WIDTH(RW)) dut (
    .i_ref_clk   (ref_clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_div_clk   (div_clk)
  );

  always #5 ref_clk = ~ref_clk;

  // Reference model: level plus edges spent in the current phase.
  logic        m_level;
  int unsigned m_elapsed;

  function automatic bit model_bypass(input logic en, input logic [RW-1:0] n);
    return !en || (int'(n) < 2);
  endfunction

  function automatic int unsigned phase_len(input logic level, input logic [RW-1:0] n);
    int unsigned nn;
    nn = int'(n);
    return level ? (nn / 2) : (nn - nn / 2);
  endfunction

  always @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      m_level   <= 1'b0;
      m_elapsed <= 0;
    end else if (model_bypass(clk_en, div_ratio)) begin
      m_level   <= 1'b0;
      m_elapsed <= 0;
    end else if (m_elapsed + 1 >= phase_len(m_level, div_ratio)) begin
      m_level   <= !m_level;
      m_elapsed <= 0;
    end else begin
      m_elapsed <= m_elapsed + 1;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Continuous compare at both reference levels.
  always begin
    @(posedge ref_clk);
    #2 check("model_hi", div_clk, model_bypass(clk_en, div_ratio) ? ref_clk : m_level);
    @(negedge ref_clk);
    #2 check("model_lo", div_clk, model_bypass(clk_en, div_ratio) ? ref_clk : m_level);
  end

  task automatic enter_divide(input logic [RW-1:0] n);
    @(negedge ref_clk);
    clk_en = 1'b0;
    @(negedge ref_clk);
    div_ratio = n;
    clk_en    = 1'b1;
  endtask

  // Bit i of pat is the expected output after the (i+1)-th rising edge.
  task automatic expect_seq(input string name, input logic [15:0] pat, input int len);
    for (int i = 0; i < len; i++) begin
      @(posedge ref_clk);
      #2 check(name, div_clk, pat[i]);
    end
  endtask

  task automatic check_bypass(input string name);
    for (int i = 0; i < 3; i++) begin
      @(posedge ref_clk);
      #3 check(name, div_clk, 1'b1);
      @(negedge ref_clk);
      #3 check(name, div_clk, 1'b0);
    end
  endtask

  initial begin
    int waited;
    rst       = 1'b1;
    clk_en    = 1'b0;
    div_ratio = '0;

    // Reset with bypass: output follows the reference at both levels.
    check_bypass("rst_bypass");
    @(negedge ref_clk);
    rst = 1'b0;

    clk_en    = 1'b1;
    div_ratio = RW'(1);
    check_bypass("bypass_n1");
    @(negedge ref_clk);
    div_ratio = RW'(0);
    check_bypass("bypass_n0");

    enter_divide(RW'(5));
    expect_seq("div5", 16'h018C, 10);
    enter_divide(RW'(6));
    expect_seq("div6", 16'h071C, 12);
    enter_divide(RW'(2));
    expect_seq("div2", 16'h0055, 8);

    // Asynchronous reset in the middle of a high phase with N=6.
    enter_divide(RW'(6));
    waited = 0;
    do begin
      @(posedge ref_clk);
      #2 waited++;
    end while (div_clk !== 1'b1 && waited < 20);
    check("wait_high", div_clk, 1'b1);
    @(posedge ref_clk);
    #3 rst = 1'b1;
    #1 check("rst_async_low", div_clk, 1'b0);
    @(posedge ref_clk);
    @(negedge ref_clk);
    rst = 1'b0;
    expect_seq("rst_release", 16'h0004, 3);

    // Randomized ratio, enable and reset activity.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge ref_clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 19) == 0) div_ratio = RW'($urandom_range(0, (1 << RW) - 1));
      if ($urandom_range(0, 39) == 0) clk_en = !clk_en;
      if (!clk_en && $urandom_range(0, 3) == 0) clk_en = 1'b1;
    end

    @(negedge ref_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
